// File: rtl/mem_io_bridge.sv
// Memory-mapped I/O bridge: routes core accesses to the external RAM or to a small peripheral
// block (cycle counter, down-counting timer, debug transmit FIFO) at 0xFF00-0xFFFF.
module mem_io_bridge (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address_to_main_memory,
   input  logic [15:0] data_to_main_memory,
   input  logic        data_to_main_memory_write_en,
   output logic [15:0] data_from_main_memory,
   output logic [15:0] ram_address,
   output logic [15:0] ram_write_data,
   output logic        ram_write_en,
   input  logic [15:0] ram_read_data,
   output logic [15:0] dbg_data,
   output logic        dbg_valid,
   input  logic        dbg_ready,
   output logic        timer_flag
);

   localparam logic [15:0] AddrCycleLo     = 16'hFF00;
   localparam logic [15:0] AddrCycleHi     = 16'hFF01;
   localparam logic [15:0] AddrTimerReload = 16'hFF02;
   localparam logic [15:0] AddrTimerCount  = 16'hFF03;
   localparam logic [15:0] AddrTimerCtrl   = 16'hFF04;
   localparam logic [15:0] AddrTimerStatus = 16'hFF05;
   localparam logic [15:0] AddrDbgTx       = 16'hFF06;
   localparam logic [15:0] AddrDbgStatus   = 16'hFF07;

   logic        periph_sel, reg_we;
   logic [31:0] cycle_q;
   logic [15:0] snap_q, reload_q, reload_d, count_q, count_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic        expired_q, expired_d, timer_expire;
   logic        periph_q;
   logic [15:0] rdata_q, periph_rdata;
   logic [15:0] fifo_mem [4];
   logic [1:0]  wr_ptr_q, rd_ptr_q;
   logic [2:0]  fifo_cnt_q, fifo_cnt_d;
   logic        ovf_q, ovf_d;
   logic        fifo_full, fifo_empty, fifo_pop, fifo_push_req, fifo_push, fifo_ovf_set;

   assign periph_sel     = address_to_main_memory[15:8] == 8'hFF;
   assign reg_we         = data_to_main_memory_write_en && periph_sel;
   assign ram_address    = address_to_main_memory;
   assign ram_write_data = data_to_main_memory;
   assign ram_write_en   = data_to_main_memory_write_en && !periph_sel;

   assign fifo_full     = fifo_cnt_q == 3'd4;
   assign fifo_empty    = fifo_cnt_q == 3'd0;
   assign fifo_pop      = !fifo_empty && dbg_ready;
   assign fifo_push_req = reg_we && (address_to_main_memory == AddrDbgTx);
   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign fifo_push     = fifo_push_req && (!fifo_full || fifo_pop);
   assign fifo_ovf_set  = fifo_push_req && fifo_full && !fifo_pop;

   assign dbg_valid  = !fifo_empty;
   assign dbg_data   = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr_q];
   assign timer_flag = expired_q;

   assign data_from_main_memory = periph_q ? rdata_q : ram_read_data;

   always_comb begin
      periph_rdata = 16'h0000;
      case (address_to_main_memory)
         AddrCycleLo:     periph_rdata = cycle_q[15:0];
         AddrCycleHi:     periph_rdata = snap_q;
         AddrTimerReload: periph_rdata = reload_q;
         AddrTimerCount:  periph_rdata = count_q;
         AddrTimerCtrl:   periph_rdata = {14'h0000, ctrl_q};
         AddrTimerStatus: periph_rdata = {15'h0000, expired_q};
         AddrDbgStatus:   periph_rdata = {10'h000, ovf_q, fifo_cnt_q, fifo_empty, fifo_full};
         default:         periph_rdata = 16'h0000;
      endcase
   end

   always_comb begin
      timer_expire = ctrl_q[0] && (count_q == 16'h0000);
      count_d      = count_q;
      ctrl_d       = ctrl_q;
      expired_d    = expired_q;
      reload_d     = reload_q;
      if (ctrl_q[0]) begin
         if (!timer_expire) begin
            count_d = count_q - 16'd1;
         end else if (ctrl_q[1]) begin
            count_d = reload_q;
         end else begin
            ctrl_d[0] = 1'b0;
         end
      end
      if (reg_we) begin
         case (address_to_main_memory)
            AddrTimerReload: reload_d = data_to_main_memory;
            AddrTimerCtrl: begin
               ctrl_d = data_to_main_memory[1:0];
               if (data_to_main_memory[0]) count_d = reload_q;
            end
            AddrTimerStatus: if (data_to_main_memory[0]) expired_d = 1'b0;
            default: ;
         endcase
      end
      // Hardware expiry beats a same-cycle software clear.
      if (timer_expire) expired_d = 1'b1;
   end

   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      case ({fifo_push, fifo_pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
      ovf_d = ovf_q;
      if (reg_we && (address_to_main_memory == AddrDbgStatus) && data_to_main_memory[5]) begin
         ovf_d = 1'b0;
      end
      if (fifo_ovf_set) ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q    <= 32'h0;
         snap_q     <= 16'h0;
         reload_q   <= 16'h0;
         count_q    <= 16'h0;
         ctrl_q     <= 2'b00;
         expired_q  <= 1'b0;
         periph_q   <= 1'b0;
         rdata_q    <= 16'h0;
         wr_ptr_q   <= 2'd0;
         rd_ptr_q   <= 2'd0;
         fifo_cnt_q <= 3'd0;
         ovf_q      <= 1'b0;
      end else begin
         cycle_q   <= cycle_q + 32'd1;
         if ((address_to_main_memory == AddrCycleLo) && !data_to_main_memory_write_en) begin
            snap_q <= cycle_q[31:16];
         end
         reload_q   <= reload_d;
         count_q    <= count_d;
         ctrl_q     <= ctrl_d;
         expired_q  <= expired_d;
         periph_q   <= periph_sel;
         rdata_q    <= periph_rdata;
         if (fifo_push) wr_ptr_q <= wr_ptr_q + 2'd1;
         if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
         fifo_cnt_q <= fifo_cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_push && !reset) fifo_mem[wr_ptr_q] <= data_to_main_memory;
   end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: directed stimulus, a cycle-level reference model compared every
// cycle, and literal expectations taken from hand-worked scenarios.
module tb_mem_io_bridge;

   logic        clk;
   logic        reset;
   logic [15:0] addr, wdata;
   logic        we;
   logic [15:0] dout, ram_address, ram_write_data, ram_read_data, dbg_data;
   logic        ram_write_en, dbg_valid, dbg_ready, timer_flag;

   int n_cmp = 0;
   int n_bad = 0;

   mem_io_bridge dut (
      .clk                          (clk),
      .reset                        (reset),
      .address_to_main_memory       (addr),
      .data_to_main_memory          (wdata),
      .data_to_main_memory_write_en (we),
      .data_from_main_memory        (dout),
      .ram_address                  (ram_address),
      .ram_write_data               (ram_write_data),
      .ram_write_en                 (ram_write_en),
      .ram_read_data                (ram_read_data),
      .dbg_data                     (dbg_data),
      .dbg_valid                    (dbg_valid),
      .dbg_ready                    (dbg_ready),
      .timer_flag                   (timer_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Small external synchronous RAM (64 words, aliased).
   logic [15:0] ram [64];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) ram[i] <= 16'h0;
         ram_read_data <= 16'h0;
      end else begin
         if (ram_write_en) ram[ram_address[5:0]] <= ram_write_data;
         ram_read_data <= ram[ram_address[5:0]];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state.
   bit          m_known = 0;
   logic [31:0] m_cycle;
   logic [15:0] m_snap, m_reload, m_count, m_prev_rd;
   bit          m_en, m_auto, m_exp, m_ovf, m_prev_p;
   logic [15:0] m_q[$];

   function automatic logic [15:0] m_read(input logic [15:0] a);
      int sz;
      logic [2:0] c;
      sz = m_q.size();
      c  = 3'(sz);
      case (a)
         16'hFF00: return m_cycle[15:0];
         16'hFF01: return m_snap;
         16'hFF02: return m_reload;
         16'hFF03: return m_count;
         16'hFF04: return {14'h0, m_auto, m_en};
         16'hFF05: return {15'h0, m_exp};
         16'hFF07: return {10'h0, m_ovf, c, sz == 0, sz == 4};
         default:  return 16'h0;
      endcase
   endfunction

   initial forever begin
      @(negedge clk);
      if (m_known) begin
         chk("dout", dout, m_prev_p ? m_prev_rd : ram_read_data);
         chk("ram_address", ram_address, addr);
         chk("ram_write_data", ram_write_data, wdata);
         chk("ram_write_en", ram_write_en, we && (addr <= 16'hFEFF));
         chk("dbg_valid", dbg_valid, m_q.size() != 0);
         chk("dbg_data", dbg_data, (m_q.size() != 0) ? m_q[0] : 16'h0);
         chk("timer_flag", timer_flag, m_exp);
      end
      if (reset) begin
         m_known = 1; m_cycle = 0; m_snap = 0; m_reload = 0; m_count = 0;
         m_en = 0; m_auto = 0; m_exp = 0; m_ovf = 0; m_prev_p = 0; m_prev_rd = 0;
         m_q.delete();
      end else if (m_known) begin
         bit expire, push, pop, accept;
         int sz;
         m_prev_rd = m_read(addr);
         m_prev_p  = addr >= 16'hFF00;
         if (addr == 16'hFF00 && !we) m_snap = m_cycle[31:16];
         m_cycle = m_cycle + 1;
         expire = m_en && (m_count == 0);
         if (m_en) begin
            if (m_count != 0) m_count = m_count - 1;
            else if (m_auto)  m_count = m_reload;
            else              m_en = 0;
         end
         if (we && addr == 16'hFF02) m_reload = wdata;
         if (we && addr == 16'hFF04) begin
            m_en = wdata[0]; m_auto = wdata[1];
            if (wdata[0]) m_count = m_reload;
         end
         if (we && addr == 16'hFF05 && wdata[0]) m_exp = 0;
         if (expire) m_exp = 1;
         sz     = m_q.size();
         pop    = (sz > 0) && dbg_ready;
         push   = we && addr == 16'hFF06;
         accept = push && (sz < 4 || pop);
         if (we && addr == 16'hFF07 && wdata[5]) m_ovf = 0;
         if (push && !accept) m_ovf = 1;
         if (pop) void'(m_q.pop_front());
         if (accept) m_q.push_back(wdata);
      end
   end

   task automatic step(input bit rst, input logic [15:0] a, input logic [15:0] d, input bit w,
                       input bit r);
      @(posedge clk);
      #1;
      reset = rst; addr = a; wdata = d; we = w; dbg_ready = r;
      #1;
   endtask

   task automatic idle(input bit r);
      step(1'b0, 16'h0100, 16'h0, 1'b0, r);
   endtask

   initial begin
      reset = 1'b1; addr = 16'h0100; wdata = 16'h0; we = 1'b0; dbg_ready = 1'b0;
      step(1, 16'h0100, 0, 0, 0);
      step(1, 16'h0100, 0, 0, 0);
      chk("rst_dbg_valid", dbg_valid, 0);
      chk("rst_timer_flag", timer_flag, 0);
      chk("rst_dout", dout, 0);

      // Cycle counter and snapshot.
      for (int i = 0; i < 10; i++) idle(0);
      step(0, 16'hFF00, 0, 0, 0);
      step(0, 16'hFF01, 0, 0, 0);
      chk("cycle_lo", dout, 16'h000A);
      idle(0);
      chk("cycle_hi", dout, 16'h0000);

      // RAM vs register decode.
      step(0, 16'h0040, 16'h1234, 1, 0);
      chk("ram_we_ram", ram_write_en, 1);
      chk("ram_addr", ram_address, 16'h0040);
      step(0, 16'hFF02, 16'h1234, 1, 0);
      chk("ram_we_reg", ram_write_en, 0);
      step(0, 16'hFF02, 0, 0, 0);
      step(0, 16'h0040, 0, 0, 0);
      chk("reload_rd", dout, 16'h1234);
      idle(0);
      chk("ram_rd", dout, 16'h1234);

      // One-shot timer.
      step(0, 16'hFF02, 16'd3, 1, 0);
      step(0, 16'hFF04, 16'h1, 1, 0);
      for (int i = 1; i <= 5; i++) begin
         idle(0);
         chk("oneshot_flag", timer_flag, i == 5);
      end
      step(0, 16'hFF04, 0, 0, 0);
      idle(0);
      chk("oneshot_ctrl", dout, 16'h0000);
      step(0, 16'hFF05, 16'h1, 1, 0);
      idle(0);
      chk("flag_cleared", timer_flag, 0);

      // Auto-reload timer.
      step(0, 16'hFF04, 16'h3, 1, 0);
      for (int i = 1; i <= 5; i++) begin
         idle(0);
         chk("auto_flag", timer_flag, i == 5);
      end
      step(0, 16'hFF05, 16'h1, 1, 0);
      idle(0);
      chk("auto_clr", timer_flag, 0);
      idle(0);
      idle(0);
      chk("auto_reassert", timer_flag, 1);
      idle(0);
      idle(0);
      step(0, 16'hFF05, 16'h1, 1, 0);
      step(0, 16'hFF04, 16'h0, 1, 0);
      chk("set_wins", timer_flag, 1);
      step(0, 16'hFF05, 16'h1, 1, 0);
      idle(0);
      chk("stopped_flag", timer_flag, 0);

      // FIFO overflow.
      for (int i = 0; i < 5; i++) step(0, 16'hFF06, 16'hA0 + 16'(i), 1, 0);
      step(0, 16'hFF07, 0, 0, 0);
      idle(0);
      chk("dbg_status_ovf", dout, 16'h0031);
      for (int i = 0; i < 4; i++) begin
         idle(1);
         chk("drain_a_valid", dbg_valid, 1);
         chk("drain_a_data", dbg_data, 16'hA0 + 16'(i));
      end
      idle(1);
      chk("drain_a_empty", dbg_valid, 0);

      // Full FIFO with simultaneous push and pop.
      step(0, 16'hFF07, 16'h0020, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 16'hFF06, 16'hC0 + 16'(i), 1, 0);
      step(0, 16'hFF06, 16'h00B0, 1, 1);
      step(0, 16'hFF07, 0, 0, 0);
      idle(0);
      chk("dbg_status_full", dout, 16'h0011);
      for (int i = 0; i < 4; i++) begin
         idle(1);
         chk("drain_b_data", dbg_data, (i == 3) ? 16'h00B0 : 16'hC1 + 16'(i));
      end
      idle(1);
      chk("drain_b_empty", dbg_valid, 0);

      // Empty FIFO with simultaneous push and pop.
      step(0, 16'hFF06, 16'h00D0, 1, 1);
      idle(0);
      chk("empty_push", dbg_data, 16'h00D0);
      idle(1);
      idle(0);

      // Reset mid-operation.
      step(0, 16'hFF02, 16'h0, 1, 0);
      step(0, 16'hFF04, 16'h3, 1, 0);
      step(0, 16'hFF06, 16'h00E0, 1, 0);
      step(0, 16'hFF06, 16'h00E1, 1, 0);
      chk("pre_rst_flag", timer_flag, 1);
      chk("pre_rst_valid", dbg_valid, 1);
      step(1, 16'h0100, 0, 0, 0);
      step(0, 16'hFF04, 0, 0, 0);
      chk("post_rst_valid", dbg_valid, 0);
      chk("post_rst_flag", timer_flag, 0);
      idle(0);
      chk("post_rst_ctrl", dout, 16'h0000);
      idle(0);
      idle(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_io_bridge.md
# mem_io_bridge

Memory-mapped I/O bridge on the core's main-memory port. Decodes every data access: addresses 0x0000–0xFEFF pass to the external synchronous data RAM, and 0xFF00–0xFFFF hit local peripherals. The peripherals are a 32-bit cycle counter, a programmable down-counting timer, and a 4-entry debug transmit FIFO with a ready/valid output. Returns read data to the core with the same one-cycle latency as the RAM.

## Interface
- No parameters; widths fixed: 16-bit address and data, FIFO depth 4.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- address_to_main_memory  in  16  core access address, valid every cycle.
- data_to_main_memory  in  16  core store data.
- data_to_main_memory_write_en  in  1  core store strobe.
- data_from_main_memory  out  16  read data returned to the core.
- ram_address  out  16  equals address_to_main_memory.
- ram_write_data  out  16  equals data_to_main_memory.
- ram_write_en  out  1  write_en AND address ≤ 0xFEFF.
- ram_read_data  in  16  RAM synchronous read data, valid one cycle after the address.
- dbg_data  out  16  FIFO head entry.
- dbg_valid  out  1  FIFO not empty.
- dbg_ready  in  1  consumer accepts; pops when dbg_valid && dbg_ready.
- timer_flag  out  1  mirrors TIMER_STATUS bit0.

## Operation
- Register map, word addresses:
  - 0xFF00 CYCLE_LO (RO): reading it snapshots CYCLE_HI.
  - 0xFF01 CYCLE_HI (RO): snapshot value.
  - 0xFF02 TIMER_RELOAD (RW).
  - 0xFF03 TIMER_COUNT (RO).
  - 0xFF04 TIMER_CTRL (RW): bit0 enable, bit1 auto-reload.
  - 0xFF05 TIMER_STATUS: bit0 expired; writing 1 clears it.
  - 0xFF06 DBG_TX (WO): push to FIFO.
  - 0xFF07 DBG_STATUS (RO, except bit5): bit0 full, bit1 empty, bits4:2 count 0–4, bit5 overflow sticky; writing bit5=1 clears bit5.
  - 0xFF08–0xFFFF: read 0; writes ignored.
- Reads of write-only or unused bits return 0. Writes to RO registers are ignored.
- Cycle counter: 32-bit, increments every non-reset cycle, wraps 0xFFFF_FFFF → 0.
- Timer:
  - Writing TIMER_CTRL with bit0=1 loads count ← RELOAD.
  - While enabled and count ≠ 0: count decrements each cycle.
  - While enabled and count = 0: expired ← 1. If auto-reload, count ← RELOAD; otherwise enable ← 0.
  - RELOAD = 0 with auto-reload: expires every cycle.
- FIFO: circular, 2-bit pointers and a 3-bit count.
  - DBG_TX write when not full: entry appended.
  - DBG_TX write when full with no pop that cycle: data dropped, overflow ← 1.
  - Full with simultaneous push and pop: both occur, count stays 4, no overflow.
  - Empty with simultaneous push and pop: pop is ignored (dbg_valid=0); push is accepted.

## Timing
- Read latency is 1 cycle. For an address presented in cycle N, data_from_main_memory in cycle N+1 is:
  - ram_read_data, if the registered region is RAM;
  - otherwise the peripheral value sampled in cycle N, before any same-cycle write takes effect.
- The CYCLE_LO read in cycle N captures counter[31:16] of cycle N into the CYCLE_HI snapshot.
- Register writes take effect at the end of the cycle they are presented in.
- RAM outputs (ram_address, ram_write_data, ram_write_en) are combinational from core inputs.
- Simultaneous timer expiry and software clear of TIMER_STATUS in the same cycle: set wins, flag stays 1.
- Reset values: data_from_main_memory=0, registered region=RAM, cycle counter=0, snapshot=0, RELOAD=0, count=0, CTRL=0, expired=0, FIFO empty, overflow=0, dbg_valid=0, dbg_data=0, timer_flag=0.
- Reset asserted mid-operation flushes the FIFO and stops the timer on the next edge. dbg_valid is 0 in the first cycle after reset.

## Test plan
- Reset, then read 0xFF00 at cycle 10 → data_from_main_memory = 0x000A at cycle 11 (counter value sampled in cycle 10; counter starts from 0 after reset). Then read 0xFF01 → 0x0000.
- Store 0x1234 to 0x0040 → ram_write_en=1 and ram_address=0x0040 in the same cycle. Store to 0xFF02 → ram_write_en=0. Read 0xFF02 → 0x1234 returned next cycle.
- RELOAD=3, CTRL=0x1 → timer_flag rises 4 cycles after the CTRL write and enable clears. Repeat with CTRL=0x3 → flag re-asserts every 4 cycles after being cleared by writing 1 to 0xFF05.
- With dbg_ready=0, push 5 words 0xA0–0xA4 → DBG_STATUS = 0x0031 (full, count 4, overflow). Then raise dbg_ready → dbg_data sequence 0xA0–0xA3 appears, after which dbg_valid=0.
- With the FIFO full and dbg_ready=1, push 0xB0 → count stays 4, overflow stays 0, 0xB0 is emitted last.
- Assert reset with 2 FIFO entries and the timer running → next cycle dbg_valid=0, timer_flag=0, and TIMER_CTRL reads 0.
